seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
// - Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
// - Sits downstream of the free-running prescaler counter; its `full` output drives `tick`.
// - Latches a hex result and an error flag from the calculator datapath on `load`.
// - Scans one digit per tick, with a one-cycle all-off gap between digits against ghosting.
// PARAMETERS
// - DIGITS      4  number of digits scanned; range 2..8
// - ACTIVE_LOW  1  1: an/seg/dp driven low = on; 0: high = on
// PORTS
// - clk        in   1          clock
// - reset      in   1          synchronous, active-high
// - tick       in   1          scan-advance strobe, 1-cycle pulse from prescaler full
// - load       in   1          latch value/dp_mask/error into shadow regs
// - value      in   4*DIGITS   hex nibbles; [3:0] = rightmost digit 0
// - dp_mask    in   DIGITS     decimal point per digit, 1 = lit
// - error      in   1          show dashes on all digits
// - blank_lz   in   1          enable leading-zero blanking (live, not latched)
// - an         out  DIGITS     digit enables, one-hot-on or all-off
// - seg        out  7          {g,f,e,d,c,b,a}
// - dp         out  1          decimal point
// - digit_idx  out  clog2(DIGITS)  index currently driven; aligned with an
// BEHAVIOUR
// - Reset: shadow value/dp/err=0; idx=0; phase=GAP; outputs all off, digit_idx=0.
//   * All off means an/seg/dp = all 1s when ACTIVE_LOW=1, all 0s otherwise.
// - Shadow: on load, value/dp_mask/error are captured at the clock edge; held until the next load.
// - FSM, two states:
//   * DRIVE: show digit idx. On tick -> GAP. Otherwise stay in DRIVE.
//   * GAP: all off for exactly 1 clk. Then -> DRIVE with idx <= (idx==DIGITS-1) ? 0 : idx+1.
//   * A tick in GAP is ignored, not queued.
//   * After reset, the first GAP exits with idx 0 -> DRIVE digit 1. This is intended.
// - Output registers: an/seg/dp/digit_idx are registered decodes of the current (phase, idx, shadow).
//   * Pins lag the state by 1 clk.
//   * load -> new pattern on pins 2 clks after the load edge when in DRIVE.
// - Digit k content, in priority order:
//   1. err shadow = 1: seg = dash (g only); dp off; no blanking applied.
//   2. blank_lz=1, k>0, and nibbles k..DIGITS-1 all zero: segments and dp off, but an[k] still asserted.
//   3. Otherwise: hex decode of nibble k (0-F, lowercase b/d); dp = dp_mask[k].
// - Polarity: all patterns are computed active-high, then inverted at the output register when ACTIVE_LOW=1.
// - Simultaneous load+tick: both act in the same cycle; the next DRIVE uses the new shadow.
// - tick held high continuously: alternate DRIVE/GAP every clk; no digit is skipped.
// - Reset mid-scan: immediate return to reset state on the next edge; shadow is lost.
// STRUCTURE
// - Package seg7_pkg:
//   * SEG_BLANK = 7'h00, SEG_DASH = 7'h40
//   * hex-to-seg localparam table (active-high)
//   * phase encoding DRIVE/GAP
// - Sub-module hex_to_seg7: combinational, 4-bit nibble -> 7-bit active-high pattern; one instance.
// - Top: shadow regs, FSM + idx counter, digit mux, blanking logic, output register.
// TESTING
// - reset, DIGITS=4, ACTIVE_LOW=1 -> an=4'hF, seg=7'h7F, dp=1 until first DRIVE.
// - load 16'h12AF, dp_mask=0, tick every 8 clks -> digit 0 shows F (seg ~7'h71).
//   * Then 1 clk all-off, then digit 1 shows A (~7'h77), digit 2 shows 2 (~7'h5B), digit 3 shows 1 (~7'h06).
//   * Digit 0 repeats after digit 3 (wrap).
// - load 16'h0005, blank_lz=1 -> an cycles through all digits.
//   * seg off for digits 3..1; digit 0 shows 5 (~7'h6D).
//   * With blank_lz=0, 0 (~7'h3F) is shown on digits 3..1.
// - load with error=1, dp_mask=4'hF -> every digit seg=~7'h40, dp off.
//   * A later load with error=0 restores hex display.
// - tick tied high -> pattern DRIVE,GAP,DRIVE...; digit_idx 0,1,2,3,0; each digit on for 1 clk.
// - load+tick same cycle, then reset asserted mid-DRIVE ->
//   * new value shown in the next DRIVE;
//   * after reset, all off, digit_idx=0, shadow=0.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// All segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    // Scan phase: show a digit, or hold everything dark for one clock.
    typedef enum logic {
        PH_DRIVE = 1'b0,
        PH_GAP   = 1'b1
    } phase_e;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_DASH  = 7'h40;

    // Hex glyphs 0..F, lowercase b and d; entry [n] is the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h71, // F
        7'h79, // E
        7'h5E, // d
        7'h39, // C
        7'h7C, // b
        7'h77, // A
        7'h6F, // 9
        7'h7F, // 8
        7'h07, // 7
        7'h7D, // 6
        7'h6D, // 5
        7'h66, // 4
        7'h4F, // 3
        7'h5B, // 2
        7'h06, // 1
        7'h3F  // 0
    };

    function automatic logic [6:0] hex_seg(input logic [3:0] nibble);
        return HEX_SEG_TABLE[nibble];
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment glyph.
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Table lookup of the glyph for the selected nibble.
    always_comb begin
        seg_o = hex_seg(nibble_i);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver.
// Latches a hex value/dp mask/error flag on load, scans one digit per tick
// with a one-clock dark gap between digits, and registers all pin outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS     = 4,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        load,
    input  logic [4*DIGITS-1:0]         value,
    input  logic [DIGITS-1:0]           dp_mask,
    input  logic                        error,
    input  logic                        blank_lz,
    output logic [DIGITS-1:0]           an,
    output logic [6:0]                  seg,
    output logic                        dp,
    output logic [$clog2(DIGITS)-1:0]   digit_idx
);

    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [DIGITS-1:0] AN_OFF   = {DIGITS{ACTIVE_LOW}};
    localparam logic [6:0]        SEG_OFF  = {7{ACTIVE_LOW}};
    localparam logic              DP_OFF   = ACTIVE_LOW;

    // Shadow registers
    logic [4*DIGITS-1:0] value_q;
    logic [DIGITS-1:0]   dpm_q;
    logic                err_q;

    // Scan state
    phase_e              phase_q, phase_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    // Digit selection
    logic [3:0]          nib_sel;
    logic                dpm_sel;
    logic                zero_above;
    logic                lz_blank;
    logic [6:0]          hex_pat;

    // Active-high patterns and polarity-adjusted next outputs
    logic [DIGITS-1:0]   an_pat;
    logic [6:0]          seg_pat;
    logic                dp_pat;
    logic [DIGITS-1:0]   an_d;
    logic [6:0]          seg_d;
    logic                dp_d;
    logic [IDX_W-1:0]    didx_d;

    // Output registers
    logic [DIGITS-1:0]   an_q;
    logic [6:0]          seg_q;
    logic                dp_q;
    logic [IDX_W-1:0]    didx_q;

    // Capture the displayed value, dp mask and error flag on load.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
            dpm_q   <= '0;
            err_q   <= 1'b0;
        end else if (load) begin
            value_q <= value;
            dpm_q   <= dp_mask;
            err_q   <= error;
        end
    end

    // Scan state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= PH_GAP;
            idx_q   <= '0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
        end
    end

    // Next scan state: leave DRIVE on tick, leave GAP after one clock and advance.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        case (phase_q)
            PH_DRIVE: begin
                if (tick) begin
                    phase_d = PH_GAP;
                end
            end
            PH_GAP: begin
                phase_d = PH_DRIVE;
                idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            end
            default: begin
                phase_d = PH_GAP;
                idx_d   = '0;
            end
        endcase
    end

    // Select nibble, dp bit and "all higher nibbles zero" for the current digit.
    always_comb begin
        nib_sel    = '0;
        dpm_sel    = 1'b0;
        zero_above = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nib_sel    = value_q[4*k +: 4];
                dpm_sel    = dpm_q[k];
                zero_above = ((value_q >> (4*k)) == '0);
            end
        end
    end

    hex_to_seg7 u_hex (
        .nibble_i (nib_sel),
        .seg_o    (hex_pat)
    );

    // Build active-high patterns (error > leading-zero blank > hex), then apply polarity.
    always_comb begin
        an_pat   = '0;
        seg_pat  = SEG_BLANK;
        dp_pat   = 1'b0;
        lz_blank = blank_lz && (idx_q != '0) && zero_above;
        if (phase_q == PH_DRIVE) begin
            an_pat = DIGITS'(1) << idx_q;
            if (err_q) begin
                seg_pat = SEG_DASH;
            end else if (!lz_blank) begin
                seg_pat = hex_pat;
                dp_pat  = dpm_sel;
            end
        end
        an_d   = ACTIVE_LOW ? ~an_pat  : an_pat;
        seg_d  = ACTIVE_LOW ? ~seg_pat : seg_pat;
        dp_d   = ACTIVE_LOW ? ~dp_pat  : dp_pat;
        didx_d = idx_q;
    end

    // Register pin outputs; they trail the scan state by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            an_q   <= AN_OFF;
            seg_q  <= SEG_OFF;
            dp_q   <= DP_OFF;
            didx_q <= '0;
        end else begin
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            didx_q <= didx_d;
        end
    end

    assign an        = an_q;
    assign seg       = seg_q;
    assign dp        = dp_q;
    assign digit_idx = didx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver, DIGITS=4, ACTIVE_LOW=1.
module tb_seg7_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic        tick;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp_mask;
    logic        error;
    logic        blank_lz;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;

    int checks = 0;
    int errors = 0;

    seg7_scan_driver #(
        .DIGITS     (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .load      (load),
        .value     (value),
        .dp_mask   (dp_mask),
        .error     (error),
        .blank_lz  (blank_lz),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .digit_idx (digit_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] m, input logic e);
        value   = v;
        dp_mask = m;
        error   = e;
        load    = 1'b1;
        step();
        load    = 1'b0;
        step();
        step();
    endtask

    // Scan with a tick every 8 clocks; es/ed are active-high expected glyph/dp per digit.
    task automatic observe_scan(input string name, input logic [3:0][6:0] es, input logic [3:0] ed);
        int   last_k   = -1;
        int   exp_k    = -1;
        bit   prev_off = 1'b0;
        bit   in_digit = 1'b0;
        bit   wrap     = 1'b0;
        int   shown    = 0;
        logic [3:0] oh;
        for (int cyc = 0; cyc < 64; cyc++) begin
            tick = (cyc % 8 == 0);
            step();
            tick = 1'b0;
            if (an === 4'hF) begin
                checks++;
                if (seg !== 7'h7F || dp !== 1'b1) begin
                    errors++;
                    $display("FAIL %s gap_dark: seg=%h dp=%b want seg=7f dp=1", name, seg, dp);
                end
                if (last_k >= 0) begin
                    checks++;
                    if (prev_off) begin
                        errors++;
                        $display("FAIL %s gap_len: dark for 2+ clocks after digit %0d, want 1", name, last_k);
                    end
                end
                prev_off = 1'b1;
                in_digit = 1'b0;
            end else begin
                if (!in_digit) begin
                    if (last_k >= 0) begin
                        exp_k = (last_k + 1) % 4;
                    end else if (prev_off) begin
                        exp_k = -1;
                        for (int i = 0; i < 4; i++) begin
                            oh = 4'b0001 << i;
                            if (an === ~oh) exp_k = i;
                        end
                    end else begin
                        exp_k = -1;
                    end
                    if (exp_k >= 0) begin
                        if (last_k == 3 && an === 4'b1110) wrap = 1'b1;
                        last_k = exp_k;
                        shown++;
                    end
                end
                in_digit = 1'b1;
                prev_off = 1'b0;
                if (exp_k >= 0) begin
                    oh = 4'b0001 << exp_k;
                    checks++;
                    if (an !== ~oh) begin
                        errors++;
                        $display("FAIL %s an: got %h want %h", name, an, ~oh);
                    end
                    checks++;
                    if (digit_idx !== 2'(exp_k)) begin
                        errors++;
                        $display("FAIL %s digit_idx: got %0d want %0d", name, digit_idx, exp_k);
                    end
                    checks++;
                    if (seg !== ~es[exp_k]) begin
                        errors++;
                        $display("FAIL %s seg[%0d]: got %h want %h", name, exp_k, seg, ~es[exp_k]);
                    end
                    checks++;
                    if (dp !== ~ed[exp_k]) begin
                        errors++;
                        $display("FAIL %s dp[%0d]: got %b want %b", name, exp_k, dp, ~ed[exp_k]);
                    end
                end
            end
        end
        checks++;
        if (shown < 5) begin
            errors++;
            $display("FAIL %s coverage: %0d digits tracked, want at least 5", name, shown);
        end
        checks++;
        if (!wrap) begin
            errors++;
            $display("FAIL %s wrap: digit 3 -> digit 0 not observed", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        step();
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: an=%h seg=%h dp=%b idx=%0d want f 7f 1 0", an, seg, dp, digit_idx);
        end
        reset = 1'b0;
        step();
        checks++;
        if (an !== 4'hF || seg !== 7'h7F) begin
            errors++;
            $display("FAIL reset_first_gap: an=%h seg=%h want f 7f", an, seg);
        end
        step();
        checks++;
        if (an !== 4'b1101 || digit_idx !== 2'd1) begin
            errors++;
            $display("FAIL reset_first_drive: an=%h idx=%0d want d 1", an, digit_idx);
        end
        checks++;
        if (seg !== ~7'h3F || dp !== 1'b1) begin
            errors++;
            $display("FAIL reset_shadow_zero: seg=%h dp=%b want %h 1", seg, dp, ~7'h3F);
        end
    endtask

    task automatic test_hex_scan();
        blank_lz = 1'b0;
        do_load(16'h12AF, 4'h0, 1'b0);
        observe_scan("hex_12AF", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000);
        do_load(16'h9B4D, 4'b0110, 1'b0);
        observe_scan("hex_9B4D_dp", {7'h6F, 7'h7C, 7'h66, 7'h5E}, 4'b0110);
    endtask

    task automatic test_blanking();
        blank_lz = 1'b1;
        do_load(16'h0005, 4'hF, 1'b0);
        observe_scan("blank_0005", {7'h00, 7'h00, 7'h00, 7'h6D}, 4'b0001);
        blank_lz = 1'b0;
        observe_scan("noblank_0005", {7'h3F, 7'h3F, 7'h3F, 7'h6D}, 4'b1111);
        blank_lz = 1'b1;
        do_load(16'h0300, 4'h0, 1'b0);
        observe_scan("blank_0300", {7'h00, 7'h4F, 7'h3F, 7'h3F}, 4'b0000);
    endtask

    task automatic test_error();
        blank_lz = 1'b0;
        do_load(16'h12AF, 4'hF, 1'b1);
        observe_scan("err_dash", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
        blank_lz = 1'b1;
        do_load(16'h0000, 4'hF, 1'b1);
        observe_scan("err_noblank", {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);
        blank_lz = 1'b0;
        do_load(16'h12AF, 4'h0, 1'b0);
        observe_scan("err_cleared", {7'h06, 7'h5B, 7'h77, 7'h71}, 4'b0000);
    endtask

    // Continuous tick from reset release: dark, d1, dark, d2, dark, d3, dark, d0, dark, d1.
    task automatic test_tick_high();
        logic [1:0] seq_k [5];
        logic [6:0] seq_s [5];
        logic [3:0] oh;
        seq_k = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        seq_s = '{7'h77, 7'h5B, 7'h06, 7'h71, 7'h77};
        reset = 1'b1;
        step();
        reset    = 1'b0;
        tick     = 1'b1;
        value    = 16'h12AF;
        dp_mask  = 4'h0;
        error    = 1'b0;
        blank_lz = 1'b0;
        load     = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL tick_high_first_gap: an=%h want f", an);
        end
        for (int i = 1; i <= 9; i++) begin
            step();
            if (i % 2 == 1) begin
                oh = 4'b0001 << seq_k[(i-1)/2];
                checks++;
                if (an !== ~oh || digit_idx !== seq_k[(i-1)/2] || seg !== ~seq_s[(i-1)/2]) begin
                    errors++;
                    $display("FAIL tick_high_drive%0d: an=%h idx=%0d seg=%h want %h %0d %h",
                             i, an, digit_idx, seg, ~oh, seq_k[(i-1)/2], ~seq_s[(i-1)/2]);
                end
            end else begin
                checks++;
                if (an !== 4'hF || seg !== 7'h7F) begin
                    errors++;
                    $display("FAIL tick_high_gap%0d: an=%h seg=%h want f 7f", i, an, seg);
                end
            end
        end
        tick = 1'b0;
    endtask

    // Continues from test_tick_high: scanner ends up parked in DRIVE on digit 2.
    task automatic test_load_tick_reset();
        step();
        step();
        step();
        step();
        step();
        checks++;
        if (an !== 4'b1011 || seg !== ~7'h5B) begin
            errors++;
            $display("FAIL ltr_parked: an=%h seg=%h want b %h", an, seg, ~7'h5B);
        end
        value = 16'h4321;
        load  = 1'b1;
        tick  = 1'b1;
        step();
        load = 1'b0;
        tick = 1'b0;
        checks++;
        if (an !== 4'b1011 || seg !== ~7'h5B) begin
            errors++;
            $display("FAIL ltr_old_pattern: an=%h seg=%h want b %h", an, seg, ~7'h5B);
        end
        step();
        checks++;
        if (an !== 4'hF) begin
            errors++;
            $display("FAIL ltr_gap: an=%h want f", an);
        end
        step();
        checks++;
        if (an !== 4'b0111 || digit_idx !== 2'd3 || seg !== ~7'h66) begin
            errors++;
            $display("FAIL ltr_new_value: an=%h idx=%0d seg=%h want 7 3 %h", an, digit_idx, seg, ~7'h66);
        end
        step();
        step();
        reset = 1'b1;
        step();
        checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0) begin
            errors++;
            $display("FAIL ltr_reset: an=%h seg=%h dp=%b idx=%0d want f 7f 1 0", an, seg, dp, digit_idx);
        end
        reset = 1'b0;
        step();
        step();
        checks++;
        if (an !== 4'b1101 || seg !== ~7'h3F) begin
            errors++;
            $display("FAIL ltr_shadow_lost: an=%h seg=%h want d %h", an, seg, ~7'h3F);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tick     = 1'b0;
        load     = 1'b0;
        value    = '0;
        dp_mask  = '0;
        error    = 1'b0;
        blank_lz = 1'b0;
        test_reset();
        test_hex_scan();
        test_blanking();
        test_error();
        test_tick_high();
        test_load_tick_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
